slack_dual_update_stream: RTL
=============================

Name: slack_dual_update_stream

Overview:
Streaming successor to the scalar-bound slack update in the ADMM loop. It consumes primal and scaled-dual vectors for every knot of the horizon, LANES elements per beat, with per-element box bounds. For each element it produces the clamped slack z = clamp(x+y, lo, hi) and the updated dual y' = (x+y) - z. It also tracks the max primal residual |x - z| over one solve, for the convergence check.

Parameters:
DIM, 12, elements per knot vector; DIM % LANES == 0 is required.
LANES, 4, elements processed per beat.
HORIZON, 10, knots per solve.
W, 16, signed fixed-point word width.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  begin a solve (sampled only in IDLE)
busy  out  1  high from the cycle after an accepted start until the done cycle
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
in_x  in  LANES x W  primal values
in_y  in  LANES x W  scaled dual values
in_lo  in  LANES x W  per-element lower bounds
in_hi  in  LANES x W  per-element upper bounds
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_z  out  LANES x W  slack
out_y  out  LANES x W  updated dual
out_last  out  1  marks the final beat of the solve
resid_max  out  W  max |x - z| over the solve
done  out  1  one-cycle pulse at end of solve

Behaviour:
- Beat count: BEATS = HORIZON * DIM / LANES. The beat counter and the out counter are both clog2(BEATS+1) bits.
- Arithmetic, all signed and saturating to [-2^(W-1), 2^(W-1)-1]:
  - s = sat(x + y)
  - z = s < lo ? lo : s > hi ? hi : s
  - if lo > hi, then z = lo
  - y' = sat(s - z)
  - r = sat(|x - z|); |-2^(W-1)| saturates to 2^(W-1)-1.
- Pipeline: 2 stages. Stage 1 registers s, x, lo, hi. Stage 2 registers z, y', r.
  - Global advance enable: en = !out_valid | out_ready.
  - Both stages shift only when en is high. Bubbles propagate as invalid stage-valid bits.
  - Latency: 2 cycles from the input handshake to out_valid, with out_ready held high. Throughput is 1 beat per cycle.
- in_ready = (state == RUN) & en & (accepted < BEATS).
- out_last is asserted with the beat whose out index equals BEATS-1.
- While out_valid is high and out_ready is low, every output stays stable.
- resid_max is cleared on start. On each stage-2 load it becomes max(resid_max, max over lanes of r). It holds its value after done until the next start.
- FSM:
  - IDLE: if start, clear counters and resid_max, go to RUN.
  - RUN: when the last beat is accepted, go to DRAIN.
  - DRAIN: when the handshake of the out_last beat completes, go to DONE.
  - DONE: done = 1 for one cycle, go to IDLE.
- start while not in IDLE is ignored.
- A handshake completing on the same cycle as a new input acceptance is legal and must not lose or duplicate a beat.
- Reset (reset == 0 at a clk edge):
  - state becomes IDLE.
  - in_ready, out_valid, out_last, done, busy = 0.
  - out_z, out_y, resid_max = 0.
  - Stage valids and counters are cleared.
  - Applies mid-solve; in-flight beats are discarded.

Decomposition:
- Package mpc_fixed_pkg holds:
  - parameter W
  - typedef logic signed [W-1:0] fixed_t
  - functions sat_add, sat_sub, clamp_box, abs_sat
- One sub-module, slack_lane, implements one lane's two-stage s/z/y'/r datapath with an en input. It is instantiated LANES times.
- The FSM, counters, handshake and residual max-reduction live in the top module.

Test Plan (W=16, DIM=12, LANES=4, HORIZON=2, so BEATS=6):
1. Bounds above: x={1,2,3,4}, y={6,5,4,3}, lo=5, hi=6 on all lanes. Expect s=7, z={6,6,6,6}, y'={1,1,1,1}, r={5,4,3,2}, and resid_max=5 at done.
2. Bounds below: x={1,2,3,4}, y=0, lo=10, hi=12. Expect z={10,10,10,10} and y'={-9,-8,-7,-6}, with resid_max=9.
3. Saturation: x={32767,-32768,0,0}, y={1,-1,0,0}, lo=-100, hi=100.
   - Expect s={32767,-32768,0,0}, z={100,-100,0,0}, y'={32667,-32668,0,0}.
   - Expect r lane0=32667 and lane1=32668 (no overflow).
4. Backpressure: stream 6 beats with out_ready low for 5 cycles after the 2nd output.
   - Outputs hold stable and in_ready drops once the pipeline is full.
   - Exactly 6 outputs in order, out_last only on the 6th, done one cycle after its handshake.
   - A start pulsed mid-run is ignored.
5. Inverted bounds: lo=5, hi=3, x=4, y=0. Expect z=5 and y'=-1.
6. Reset mid-op: drive reset low after the 3rd input beat.
   - Next cycle every output is 0 and state is IDLE.
   - A fresh start then completes all 6 beats with correct values and one done pulse.

Source files
------------

// File: rtl/mpc_fixed_pkg.sv
// Signed fixed-point helpers shared by the ADMM slack/dual update datapath.
// All arithmetic saturates to the W-bit signed range.
package mpc_fixed_pkg;

  localparam int W = 16;

  typedef logic signed [W-1:0] fixed_t;
  typedef logic signed [W:0]   wide_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam fixed_t FIX_MAX = {1'b0, {(W-1){1'b1}}};
  localparam fixed_t FIX_MIN = {1'b1, {(W-1){1'b0}}};

  function automatic fixed_t sat_w(input wide_t v);
    if (v > wide_t'(FIX_MAX))      return FIX_MAX;
    else if (v < wide_t'(FIX_MIN)) return FIX_MIN;
    else                           return v[W-1:0];
  endfunction

  function automatic fixed_t sat_add(input fixed_t a, input fixed_t b);
    return sat_w(wide_t'(a) + wide_t'(b));
  endfunction

  function automatic fixed_t sat_sub(input fixed_t a, input fixed_t b);
    return sat_w(wide_t'(a) - wide_t'(b));
  endfunction

  // An empty box (lo > hi) collapses onto its lower bound.
  function automatic fixed_t clamp_box(input fixed_t s, input fixed_t lo, input fixed_t hi);
    if (lo > hi)      return lo;
    else if (s < lo)  return lo;
    else if (s > hi)  return hi;
    else              return s;
  endfunction

  // Magnitude of an exact (W+1)-bit difference, saturated to the W-bit maximum.
  function automatic fixed_t abs_sat(input wide_t v);
    logic signed [W+1:0] e;
    logic signed [W+1:0] m;
    e = {v[W], v};
    m = e[W+1] ? -e : e;
    if (m > (W+2)'(FIX_MAX)) return FIX_MAX;
    else                     return m[W-1:0];
  endfunction

endpackage

// File: rtl/slack_lane.sv
// One lane of the two-stage slack datapath: stage 1 holds s=sat(x+y) with x and
// the box, stage 2 holds the clamped slack z and updated dual y'.
module slack_lane
  import mpc_fixed_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   en,
  input  fixed_t x,
  input  fixed_t y,
  input  fixed_t lo,
  input  fixed_t hi,
  output fixed_t z,
  output fixed_t yo,
  output fixed_t r_d
);

  fixed_t s1, x1, lo1, hi1;
  fixed_t z_c, y_c;

  // r_d is the residual being loaded into stage 2 this cycle.
  always_comb begin
    z_c = clamp_box(s1, lo1, hi1);
    y_c = sat_sub(s1, z_c);
    r_d = abs_sat(wide_t'(x1) - wide_t'(z_c));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1  <= '0;
      x1  <= '0;
      lo1 <= '0;
      hi1 <= '0;
      z   <= '0;
      yo  <= '0;
    end else if (en) begin
      s1  <= sat_add(x, y);
      x1  <= x;
      lo1 <= lo;
      hi1 <= hi;
      z   <= z_c;
      yo  <= y_c;
    end
  end

endmodule

// File: rtl/slack_dual_update_stream.sv
// Streaming clamp of x+y into per-element boxes with dual update and a running
// max primal residual. Handshake: a beat moves when valid & ready are both high.
module slack_dual_update_stream
  import mpc_fixed_pkg::*;
#(
  parameter int DIM     = 12,
  parameter int LANES   = 4,
  parameter int HORIZON = 10,
  parameter int W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_x,
  input  logic [LANES*W-1:0] in_y,
  input  logic [LANES*W-1:0] in_lo,
  input  logic [LANES*W-1:0] in_hi,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_z,
  output logic [LANES*W-1:0] out_y,
  output logic               out_last,
  output logic [W-1:0]       resid_max,
  output logic               done,
  output logic [1:0]         dbg_state
);

  localparam int BEATS = HORIZON * DIM / LANES;
  localparam int CW    = $clog2(BEATS + 1);
  localparam logic [CW-1:0] BEATS_C = CW'(BEATS);
  localparam logic [CW-1:0] LAST_C  = CW'(BEATS - 1);

  state_t          state, state_nx;
  logic [CW-1:0]   acc_cnt, out_cnt;
  logic            v1, en, accept, out_hs;
  fixed_t          r_d [LANES];
  fixed_t          r_lane_max;
  fixed_t          resid_q;

  // One enable for the whole pipe, so a stalled output freezes both stages.
  assign en        = !out_valid | out_ready;
  assign in_ready  = (state == ST_RUN) & en & (acc_cnt < BEATS_C);
  assign accept    = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign out_last  = out_valid & (out_cnt == LAST_C);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign resid_max = resid_q;
  assign dbg_state = state;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    slack_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .x     (in_x[i*W +: W]),
      .y     (in_y[i*W +: W]),
      .lo    (in_lo[i*W +: W]),
      .hi    (in_hi[i*W +: W]),
      .z     (out_z[i*W +: W]),
      .yo    (out_y[i*W +: W]),
      .r_d   (r_d[i])
    );
  end

  always_comb begin
    r_lane_max = r_d[0];
    for (int i = 1; i < LANES; i++) begin
      if (r_d[i] > r_lane_max) r_lane_max = r_d[i];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_RUN;
      ST_RUN:   if (accept && acc_cnt == LAST_C) state_nx = ST_DRAIN;
      ST_DRAIN: if (out_hs && out_last) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      acc_cnt   <= '0;
      out_cnt   <= '0;
      v1        <= 1'b0;
      out_valid <= 1'b0;
      resid_q   <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && start) begin
        acc_cnt <= '0;
        out_cnt <= '0;
        resid_q <= '0;
      end else begin
        if (accept) acc_cnt <= acc_cnt + 1'b1;
        if (out_hs) out_cnt <= out_cnt + 1'b1;
        if (en && v1 && r_lane_max > resid_q) resid_q <= r_lane_max;
      end
      if (en) begin
        v1        <= accept;
        out_valid <= v1;
      end
    end
  end

endmodule
